// File: rtl/mem_align_unit.sv
// rtl/mem_align_unit.sv - memory-stage sequencer splitting misaligned loads/stores into byte accesses
// Aligned requests pass straight through; misaligned LH/LHU/SH/LW/SW become N single-byte accesses.
module mem_align_unit #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [2:0]            req_funct3,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_W-1:0]     load_data,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  output logic [2:0]            Funct3,
  input  logic [DATA_W-1:0]     rd
);

  typedef enum logic {S_IDLE, S_SPLIT} state_t;

  state_t                state_q;
  logic [1:0]            idx_q;
  logic [1:0]            last_q;
  logic [DM_ADDRESS-1:0] base_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            funct3_q;
  logic                  is_read_q;
  logic [23:0]           acc_q;

  logic       req_any;
  logic       half_mis;
  logic       word_mis;
  logic       misaligned;
  logic [1:0] req_last;
  logic       split_last;
  logic [7:0] split_wbyte;
  logic [15:0] half_val;

  assign req_any     = req_read | req_write;
  assign half_mis    = ((req_funct3 == 3'b001) || (req_funct3 == 3'b101)) && req_addr[0];
  assign word_mis    = (req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00);
  assign misaligned  = req_any && (half_mis || word_mis);
  assign req_last    = word_mis ? 2'd3 : 2'd1;
  assign split_last  = (idx_q == last_q);
  assign split_wbyte = wdata_q[{idx_q, 3'b000} +: 8];
  assign half_val    = {rd[7:0], acc_q[7:0]};

  always_comb begin
    stall     = 1'b0;
    done      = 1'b0;
    load_data = '0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    a         = '0;
    wd        = '0;
    Funct3    = 3'b000;
    if (!reset) begin
      if (state_q == S_IDLE) begin
        MemRead  = req_read;
        MemWrite = req_write & ~req_read;
        a        = req_addr;
        if (misaligned) begin
          stall  = 1'b1;
          Funct3 = req_read ? 3'b100 : 3'b000;
          wd     = req_read ? '0 : {{(DATA_W-8){1'b0}}, req_wdata[7:0]};
        end else begin
          done      = req_any;
          Funct3    = req_funct3;
          wd        = req_wdata;
          load_data = req_read ? rd : '0;
        end
      end else begin
        // Split byte accesses rely only on the latched request.
        MemRead  = is_read_q;
        MemWrite = ~is_read_q;
        a        = base_q + {{(DM_ADDRESS-2){1'b0}}, idx_q};
        Funct3   = is_read_q ? 3'b100 : 3'b000;
        wd       = is_read_q ? '0 : {{(DATA_W-8){1'b0}}, split_wbyte};
        stall    = ~split_last;
        done     = split_last;
        if (split_last && is_read_q) begin
          if (last_q == 2'd3)
            load_data = {rd[7:0], acc_q};
          else if (funct3_q == 3'b101)
            load_data = {{(DATA_W-16){1'b0}}, half_val};
          else
            load_data = {{(DATA_W-16){half_val[15]}}, half_val};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      last_q    <= 2'd0;
      base_q    <= '0;
      wdata_q   <= '0;
      funct3_q  <= 3'b000;
      is_read_q <= 1'b0;
      acc_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (misaligned) begin
            state_q   <= S_SPLIT;
            idx_q     <= 2'd1;
            last_q    <= req_last;
            base_q    <= req_addr;
            wdata_q   <= req_wdata;
            funct3_q  <= req_funct3;
            is_read_q <= req_read;
            acc_q     <= {16'b0, rd[7:0]};
          end
        end
        S_SPLIT: begin
          if (split_last) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
          end else begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
              2'd1:    acc_q[15:8]  <= rd[7:0];
              2'd2:    acc_q[23:16] <= rd[7:0];
              default: acc_q        <= acc_q;
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_align_unit.sv
// tb/tb_mem_align_unit.sv - randomized self-checking bench for mem_align_unit
// A byte-array data memory sits behind the DUT; a separate reference array tracks expected contents.
module tb_mem_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_read, req_write;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        stall, done, MemRead, MemWrite;
  logic [31:0] load_data, wd, rd;
  logic [8:0]  a;
  logic [2:0]  Funct3;

  logic [7:0]  mem     [512];
  logic [7:0]  ref_mem [512];
  logic        load_mem;
  logic [8:0]  a1, a2, a3;
  logic [31:0] last_ld;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_align_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_funct3(req_funct3),
    .stall(stall), .done(done), .load_data(load_data),
    .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .Funct3(Funct3),
    .rd(rd)
  );

  assign a1 = a + 9'd1;
  assign a2 = a + 9'd2;
  assign a3 = a + 9'd3;

  // Data memory: combinational read with width/extension by Funct3, write on the clock edge.
  always_comb begin
    case (Funct3)
      3'b000:  rd = {{24{mem[a][7]}}, mem[a]};
      3'b100:  rd = {24'b0, mem[a]};
      3'b001:  rd = {{16{mem[a1][7]}}, mem[a1], mem[a]};
      3'b101:  rd = {16'b0, mem[a1], mem[a]};
      default: rd = {mem[a3], mem[a2], mem[a1], mem[a]};
    endcase
  end

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 512; i++) mem[i] <= ref_mem[i];
    end else if (MemWrite) begin
      mem[a] <= wd[7:0];
      if (Funct3 == 3'b001 || Funct3 == 3'b010) mem[a1] <= wd[15:8];
      if (Funct3 == 3'b010) begin
        mem[a2] <= wd[23:16];
        mem[a3] <= wd[31:24];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // One request held for its full length; expectations come from ref_mem and the access rules.
  task automatic do_req(input logic r, input logic w, input logic [8:0] ad,
                        input logic [31:0] wdat, input logic [2:0] f3);
    int          n, nb;
    logic        eff_r, eff_w;
    logic [31:0] val;
    logic [8:0]  ak;
    eff_r = r;
    eff_w = w & ~r;
    n = 1;
    if ((f3 == 3'b001 || f3 == 3'b101) && ad[0]) n = 2;
    if (f3 == 3'b010 && ad[1:0] != 2'b00) n = 4;
    nb = (f3 == 3'b000 || f3 == 3'b100) ? 1 : ((f3 == 3'b001 || f3 == 3'b101) ? 2 : 4);
    val = 0;
    for (int k = 0; k < nb; k++) begin
      ak = ad + 9'(k);
      val = val | (32'(ref_mem[ak]) << (8 * k));
    end
    if (f3 == 3'b000) val = {{24{val[7]}}, val[7:0]};
    if (f3 == 3'b001) val = {{16{val[15]}}, val[15:0]};
    req_read = r; req_write = w; req_addr = ad; req_wdata = wdat; req_funct3 = f3;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ak = (n == 1) ? ad : ad + 9'(k);
      chk("addr", {23'b0, a}, {23'b0, ak});
      chk("memread", {31'b0, MemRead}, {31'b0, eff_r});
      chk("memwrite", {31'b0, MemWrite}, {31'b0, eff_w});
      chk("stall", {31'b0, stall}, {31'b0, k < n - 1});
      chk("done", {31'b0, done}, {31'b0, k == n - 1});
      chk("funct3", {29'b0, Funct3}, {29'b0, (n == 1) ? f3 : (eff_r ? 3'b100 : 3'b000)});
      if (eff_w) chk("wd", wd, (n == 1) ? wdat : {24'b0, wdat[8*k +: 8]});
      if (eff_r && n > 1 && k > 0) chk("wd_read_zero", wd, 32'h0);
      if (k == n - 1) begin
        chk("load_data", load_data, eff_r ? val : 32'h0);
        last_ld = load_data;
      end
      @(posedge clk); #1;
    end
    if (eff_w) begin
      for (int k = 0; k < nb; k++) begin
        ak = ad + 9'(k);
        ref_mem[ak] = wdat[8*k +: 8];
      end
    end
  endtask

  task automatic idle_cycle();
    req_read = 1'b0; req_write = 1'b0;
    @(negedge clk);
    chk("idle_done", {31'b0, done}, 32'h0);
    chk("idle_write", {31'b0, MemWrite}, 32'h0);
    chk("idle_stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0] rd_f3 [5];
    int         kind, ndiff;
    logic [8:0] ad;
    rd_f3[0] = 3'b000; rd_f3[1] = 3'b001; rd_f3[2] = 3'b010; rd_f3[3] = 3'b100; rd_f3[4] = 3'b101;
    for (int i = 0; i < 512; i++) ref_mem[i] = 8'($urandom);
    ref_mem[9'h010] = 8'hEF; ref_mem[9'h011] = 8'hBE; ref_mem[9'h012] = 8'hAD; ref_mem[9'h013] = 8'hDE;
    ref_mem[9'h021] = 8'h34; ref_mem[9'h022] = 8'h92;
    reset = 1'b1; load_mem = 1'b1;
    req_read = 1'b1; req_write = 1'b0; req_addr = 9'h011; req_wdata = 32'hFFFF_FFFF; req_funct3 = 3'b010;
    @(posedge clk); #1;
    load_mem = 1'b0;
    @(negedge clk);
    chk("rst_memread", {31'b0, MemRead}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_load", load_data, 32'h0);
    chk("rst_a_wd", {wd[22:0], a}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    do_req(1, 0, 9'h010, 32'h0, 3'b010);
    chk("tp1_lw", last_ld, 32'hDEADBEEF);
    do_req(0, 1, 9'h011, 32'h11, 3'b000);
    do_req(0, 1, 9'h012, 32'h22, 3'b000);
    do_req(0, 1, 9'h013, 32'h33, 3'b000);
    do_req(0, 1, 9'h014, 32'h44, 3'b000);
    do_req(1, 0, 9'h011, 32'h0, 3'b010);
    chk("tp2_lw_mis", last_ld, 32'h44332211);
    do_req(1, 0, 9'h021, 32'h0, 3'b001);
    chk("tp3_lh", last_ld, 32'hFFFF9234);
    do_req(1, 0, 9'h021, 32'h0, 3'b101);
    chk("tp3_lhu", last_ld, 32'h00009234);
    do_req(0, 1, 9'h1FE, 32'hA1B2C3D4, 3'b010);
    do_req(1, 0, 9'h000, 32'h0, 3'b010);
    chk("tp4_low", {16'b0, last_ld[15:0]}, 32'h0000A1B2);
    do_req(1, 0, 9'h1FC, 32'h0, 3'b010);
    chk("tp4_high", {16'b0, last_ld[31:16]}, 32'h0000C3D4);

    req_read = 1'b1; req_write = 1'b0; req_addr = 9'h013; req_funct3 = 3'b010;
    @(negedge clk);
    chk("tp5_c1_stall", {31'b0, stall}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("tp5_rst_stall", {31'b0, stall}, 32'h0);
    chk("tp5_rst_done", {31'b0, done}, 32'h0);
    chk("tp5_rst_read", {31'b0, MemRead}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; req_read = 1'b0;
    @(negedge clk);
    chk("tp5_post_stall", {31'b0, stall}, 32'h0);
    chk("tp5_post_done", {31'b0, done}, 32'h0);
    chk("tp5_post_read", {31'b0, MemRead}, 32'h0);
    @(posedge clk); #1;

    do_req(1, 1, 9'h040, 32'h12345678, 3'b010);
    do_req(1, 0, 9'h021, 32'h0, 3'b001);
    do_req(1, 0, 9'h022, 32'h0, 3'b000);

    for (int t = 0; t < 300; t++) begin
      kind = int'($urandom_range(0, 2));
      ad = 9'($urandom);
      if ($urandom_range(0, 7) == 0) ad = 9'h1FD + 9'($urandom_range(0, 2));
      if (kind == 1) do_req(0, 1, ad, $urandom, rd_f3[$urandom_range(0, 2)]);
      else do_req(1, kind == 2, ad, $urandom, rd_f3[$urandom_range(0, 4)]);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

    idle_cycle();
    ndiff = 0;
    for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) ndiff++;
    chk("mem_bytes_diff", ndiff, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
